// File: rtl/uart_frame_parser.sv
// uart_frame_parser: frames UART bytes into header/cmd/len/payload/xor-checksum commands
module uart_frame_parser #(
  parameter int MAX_LEN     = 16,
  parameter logic [7:0] HEADER = 8'hAA,
  parameter int TIMEOUT_CYC = 250000,
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int AW = $clog2(MAX_LEN),
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_busy,
  input  logic [7:0]    rx_byte,
  output logic          frame_valid,
  output logic          frame_err,
  output logic [1:0]    err_code,
  output logic [7:0]    frame_cmd,
  output logic [LW-1:0] frame_len,
  output logic          frame_busy,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  typedef enum logic [2:0] {IDLE, CMD, LEN, PAYLOAD, CHK} state_t;

  state_t        state_q, state_d;
  logic          rx_busy_q;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic [7:0]    fcmd_q, fcmd_d;
  logic [LW-1:0] flen_q, flen_d;
  logic [7:0]    buf_q [MAX_LEN];
  logic          wr_en;
  logic          byte_stb;
  logic          tmo_hit;

  assign byte_stb    = rx_busy_q & ~rx_busy;
  assign tmo_hit     = (state_q != IDLE) & ~byte_stb & ~rx_busy & (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign err_code    = code_q;
  assign frame_cmd   = fcmd_q;
  assign frame_len   = flen_q;
  assign frame_busy  = state_q != IDLE;
  assign rd_data     = buf_q[rd_addr];

  // next-state: frame sequencing, checksum accumulation, timeout and result pulses
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    fcmd_d  = fcmd_q;
    flen_d  = flen_q;
    wr_en   = 1'b0;
    tmo_d   = (state_q == IDLE || byte_stb) ? '0 : (rx_busy ? tmo_q : tmo_q + TW'(1));
    if (byte_stb) begin
      case (state_q)
        IDLE:    state_d = (rx_byte == HEADER) ? CMD : IDLE;
        CMD: begin
          cmd_d   = rx_byte;
          chk_d   = rx_byte;
          state_d = LEN;
        end
        LEN: begin
          if (rx_byte > 8'(MAX_LEN)) begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = IDLE;
          end else begin
            len_d   = rx_byte[LW-1:0];
            chk_d   = chk_q ^ rx_byte;
            idx_d   = '0;
            state_d = (rx_byte != 8'd0) ? PAYLOAD : CHK;
          end
        end
        PAYLOAD: begin
          wr_en   = 1'b1;
          chk_d   = chk_q ^ rx_byte;
          idx_d   = idx_q + AW'(1);
          state_d = (LW'(idx_q) == len_q - LW'(1)) ? CHK : PAYLOAD;
        end
        CHK: begin
          valid_d = rx_byte == chk_q;
          err_d   = rx_byte != chk_q;
          code_d  = (rx_byte == chk_q) ? code_q : 2'd2;
          fcmd_d  = (rx_byte == chk_q) ? cmd_q : fcmd_q;
          flen_d  = (rx_byte == chk_q) ? len_q : flen_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_hit) begin
      err_d   = 1'b1;
      code_d  = 2'd3;
      state_d = IDLE;
      tmo_d   = '0;
    end
  end

  // control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rx_busy_q <= 1'b0;
      tmo_q     <= '0;
      cmd_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      chk_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= '0;
      fcmd_q    <= '0;
      flen_q    <= '0;
    end else begin
      state_q   <= state_d;
      rx_busy_q <= rx_busy;
      tmo_q     <= tmo_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      code_q    <= code_d;
      fcmd_q    <= fcmd_d;
      flen_q    <= flen_d;
    end
  end

  // payload buffer, written in place as bytes arrive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= '0;
    end else if (wr_en) begin
      buf_q[idx_q] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed self-checking bench for uart_frame_parser
module tb_uart_frame_parser;

  localparam int T = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_busy = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       frame_valid, frame_err, frame_busy;
  logic [1:0] err_code;
  logic [7:0] frame_cmd, rd_data;
  logic [4:0] frame_len;
  logic [3:0] rd_addr = 4'd0;
  int         n_cmp = 0;
  int         n_bad = 0;

  uart_frame_parser #(.MAX_LEN(16), .HEADER(8'hAA), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_busy(rx_busy), .rx_byte(rx_byte),
    .frame_valid(frame_valid), .frame_err(frame_err), .err_code(err_code),
    .frame_cmd(frame_cmd), .frame_len(frame_len), .frame_busy(frame_busy),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rx_busy = 1'b0;
    rx_byte = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, frame_valid, 0);
    check({tag, "_err"}, frame_err, 0);
    check({tag, "_code"}, err_code, 0);
    check({tag, "_cmd"}, frame_cmd, 0);
    check({tag, "_len"}, frame_len, 0);
    check({tag, "_busy"}, frame_busy, 0);
  endtask

  task automatic good_frame(input string tag);
    send(8'hAA); send(8'h01); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33); send(8'h02);
    check({tag, "_valid"}, frame_valid, 1);
    check({tag, "_err"}, frame_err, 0);
    check({tag, "_cmd"}, frame_cmd, 8'h01);
    check({tag, "_len"}, frame_len, 3);
    check({tag, "_busy"}, frame_busy, 0);
    @(posedge clk); #1;
    check({tag, "_valid_1cyc"}, frame_valid, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("rst_buf0", rd_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(8'hAA);
    check("hdr_busy", frame_busy, 1);
    send(8'h01); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33);
    check("pre_chk_valid", frame_valid, 0);
    send(8'h02);
    check("g1_valid", frame_valid, 1);
    check("g1_err", frame_err, 0);
    check("g1_cmd", frame_cmd, 8'h01);
    check("g1_len", frame_len, 3);
    check("g1_busy", frame_busy, 0);
    @(posedge clk); #1;
    check("g1_valid_1cyc", frame_valid, 0);
    rd_addr = 4'd0; #1 check("g1_rd0", rd_data, 8'h11);
    rd_addr = 4'd1; #1 check("g1_rd1", rd_data, 8'h22);
    rd_addr = 4'd2; #1 check("g1_rd2", rd_data, 8'h33);

    send(8'hAA); send(8'h05); send(8'h00); send(8'h05);
    check("z_valid", frame_valid, 1);
    check("z_cmd", frame_cmd, 8'h05);
    check("z_len", frame_len, 0);

    send(8'hAA); send(8'h01); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33); send(8'h07);
    check("bc_err", frame_err, 1);
    check("bc_valid", frame_valid, 0);
    check("bc_code", err_code, 2);
    check("bc_cmd_kept", frame_cmd, 8'h05);
    check("bc_len_kept", frame_len, 0);
    check("bc_busy", frame_busy, 0);
    @(posedge clk); #1;
    check("bc_err_1cyc", frame_err, 0);
    check("bc_code_held", err_code, 2);
    good_frame("g2");

    send(8'hAA); send(8'h01); send(8'h11);
    check("ol_err", frame_err, 1);
    check("ol_code", err_code, 1);
    check("ol_busy", frame_busy, 0);

    send(8'hAA); send(8'h02); send(8'h10);
    check("max_busy", frame_busy, 1);
    for (int i = 0; i < 16; i++) send(8'(i));
    send(8'h12);
    check("max_valid", frame_valid, 1);
    check("max_len", frame_len, 16);
    check("max_cmd", frame_cmd, 8'h02);
    rd_addr = 4'd15; #1 check("max_rd15", rd_data, 8'h0F);

    send(8'h3C);
    check("junk1_busy", frame_busy, 0);
    send(8'h55);
    check("junk2_busy", frame_busy, 0);
    check("junk_err", frame_err, 0);
    send(8'hAA); send(8'h01); send(8'h02); send(8'h11);
    repeat (T - 1) @(posedge clk);
    #1;
    check("to_early", frame_err, 0);
    check("to_busy_early", frame_busy, 1);
    @(posedge clk); #1;
    check("to_err", frame_err, 1);
    check("to_code", err_code, 3);
    check("to_busy", frame_busy, 0);
    check("to_cmd_kept", frame_cmd, 8'h02);

    send(8'hAA); send(8'h01); send(8'h03); send(8'h11);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mr");
    rd_addr = 4'd0; #1 check("mr_buf0", rd_data, 0);
    @(posedge clk); #1;
    check("mr_err", frame_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    good_frame("g3");
    rd_addr = 4'd1; #1 check("g3_rd1", rd_data, 8'h22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
